// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit retiring BPC bits per cycle.
// Divide-by-zero, signed overflow and last-result cache hits finish without iterating.
module mdu_iter #(
  parameter int XLEN     = 32,
  parameter int BPC      = 2,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic            s_clk_i,
  input  logic            s_resetn_i,
  input  logic            s_stall_i,
  input  logic            s_flush_i,
  input  logic            s_compute_i,
  input  logic [2:0]      s_op_i,
  input  logic [XLEN-1:0] s_operand1_i,
  input  logic [XLEN-1:0] s_operand2_i,
  output logic            s_finished_o,
  output logic [XLEN-1:0] s_result_o
);
  localparam int NITER = XLEN / BPC;
  localparam int CW = $clog2(NITER + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]   cnt_q;
  logic [2:0]      op_q;
  logic [XLEN-1:0] a_q, b_q, dvs_q, hi_q, lo_q;
  logic            sa_q, sb_q, neg_a_q, neg_b_q;

  logic            c_vld_q, c_div_q, c_sa_q, c_sb_q;
  logic [XLEN-1:0] c_a_q, c_b_q, c_hi_q, c_lo_q;

  logic            start, abort, in_div, in_sa, in_sb, in_neg_a, in_neg_b;
  logic            div_zero, div_ovf, special, hit, sel_lo;
  logic [XLEN-1:0] in_mag_a, in_mag_b, sp_hi, sp_lo;
  logic [XLEN-1:0] step_hi, step_lo, fin_hi, fin_lo;
  logic [XLEN:0]   rem, sum;

  assign start    = s_compute_i && !s_flush_i;
  assign abort    = s_flush_i || !s_compute_i;
  assign in_div   = s_op_i[2];
  assign in_sa    = in_div ? !s_op_i[0] : (s_op_i != 3'b011);
  assign in_sb    = in_div ? !s_op_i[0] : !s_op_i[1];
  assign in_neg_a = in_sa && s_operand1_i[XLEN-1];
  assign in_neg_b = in_sb && s_operand2_i[XLEN-1];
  assign in_mag_a = in_neg_a ? -s_operand1_i : s_operand1_i;
  assign in_mag_b = in_neg_b ? -s_operand2_i : s_operand2_i;

  assign div_zero = in_div && (s_operand2_i == '0);
  assign div_ovf  = in_div && !s_op_i[0] && (s_operand1_i == MIN_NEG) && (s_operand2_i == '1);
  assign special  = div_zero || div_ovf;
  // hi holds the remainder and lo the quotient for divides
  assign sp_hi    = div_zero ? s_operand1_i : '0;
  assign sp_lo    = div_zero ? '1 : s_operand1_i;

  // MUL only needs the low half, which is identical for every signedness pair
  assign hit = CACHE_EN && c_vld_q && (c_a_q == s_operand1_i) && (c_b_q == s_operand2_i) &&
               (c_div_q == in_div) &&
               (in_div ? (c_sa_q == in_sa)
                       : ((s_op_i == 3'b000) || ((c_sa_q == in_sa) && (c_sb_q == in_sb))));

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (special || hit) ? DONE : CALC;
      CALC:    if (abort) state_d = IDLE;
               else if (cnt_q == CW'(1)) state_d = DONE;
      DONE:    if (abort || !s_stall_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One iteration: BPC shift-add or restoring-divide steps, plus sign fix-up for the last one
  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    rem     = '0;
    sum     = '0;
    for (int i = 0; i < BPC; i++) begin
      if (op_q[2]) begin
        rem     = {step_hi, step_lo[XLEN-1]};
        step_lo = {step_lo[XLEN-2:0], 1'b0};
        if (rem >= {1'b0, dvs_q}) begin
          rem        = rem - {1'b0, dvs_q};
          step_lo[0] = 1'b1;
        end
        step_hi = rem[XLEN-1:0];
      end else begin
        sum                = {1'b0, step_hi} + (step_lo[0] ? {1'b0, dvs_q} : '0);
        {step_hi, step_lo} = {sum, step_lo[XLEN-1:1]};
      end
    end
    fin_hi = step_hi;
    fin_lo = step_lo;
    if (op_q[2]) begin
      if (neg_a_q ^ neg_b_q) fin_lo = -step_lo;
      if (neg_a_q)           fin_hi = -step_hi;
    end else if (neg_a_q ^ neg_b_q) begin
      {fin_hi, fin_lo} = -{step_hi, step_lo};
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      c_vld_q <= 1'b0;
      c_div_q <= 1'b0;
      c_sa_q  <= 1'b0;
      c_sb_q  <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_hi_q  <= '0;
      c_lo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          op_q    <= s_op_i;
          a_q     <= s_operand1_i;
          b_q     <= s_operand2_i;
          sa_q    <= in_sa;
          sb_q    <= in_sb;
          neg_a_q <= in_neg_a;
          neg_b_q <= in_neg_b;
          dvs_q   <= in_div ? in_mag_b : in_mag_a;
          cnt_q   <= '0;
          if (special) begin
            hi_q <= sp_hi;
            lo_q <= sp_lo;
          end else if (hit) begin
            // keep the entry's signedness so the write-back leaves it unchanged
            hi_q <= c_hi_q;
            lo_q <= c_lo_q;
            sa_q <= c_sa_q;
            sb_q <= c_sb_q;
          end else begin
            hi_q  <= '0;
            lo_q  <= in_div ? in_mag_a : in_mag_b;
            cnt_q <= CW'(NITER);
          end
        end
        CALC: if (abort) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q - CW'(1);
          hi_q  <= (cnt_q == CW'(1)) ? fin_hi : step_hi;
          lo_q  <= (cnt_q == CW'(1)) ? fin_lo : step_lo;
        end
        DONE: if (CACHE_EN && !abort && !s_stall_i) begin
          c_vld_q <= 1'b1;
          c_div_q <= op_q[2];
          c_sa_q  <= sa_q;
          c_sb_q  <= sb_q;
          c_a_q   <= a_q;
          c_b_q   <= b_q;
          c_hi_q  <= hi_q;
          c_lo_q  <= lo_q;
        end
        default: ;
      endcase
    end
  end

  assign sel_lo       = op_q[2] ? !op_q[1] : (op_q[1:0] == 2'b00);
  assign s_finished_o = (state_q == DONE);
  assign s_result_o   = s_finished_o ? (sel_lo ? lo_q : hi_q) : '0;

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage executor.
- Successor to the fixed-width MDU; it is generalised in XLEN and in radix (bits retired per cycle).
- Adds three behaviours the previous unit lacks:
  - single-cycle handling of divide-by-zero and signed overflow;
  - an optional result cache, so paired MUL/MULH and DIV/REM on the same operands finish without iterating;
  - stall-safe result holding.
- Results are bit-exact to the RISC-V M extension.

Parameters:
- XLEN, 32, operand and result width.
- BPC, 2, bits processed per iteration cycle; legal values are 1, 2 and 4, and BPC must divide XLEN.
- CACHE_EN, 1, enables the last-result cache (1 = on, 0 = every operation iterates).

Ports:
- s_clk_i  in  1  clock
- s_resetn_i  in  1  reset; asynchronous, active-low
- s_stall_i  in  1  EX stage stalled by MA
- s_flush_i  in  1  pipeline flush from MA
- s_compute_i  in  1  a valid M-extension instruction is in EX; held high until it leaves
- s_op_i  in  3  RISC-V funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- s_operand1_i  in  XLEN  rs1 value
- s_operand2_i  in  XLEN  rs2 value
- s_finished_o  out  1  result valid this cycle
- s_result_o  out  XLEN  result; 0 whenever s_finished_o=0

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - s_finished_o=0 and s_result_o=0.
  - Cache is invalidated and the iteration counter is 0.
- FSM states: IDLE, CALC, DONE.
- IDLE, when s_compute_i=1 and s_flush_i=0:
  - Latch op and operands.
  - If a special case or cache hit applies, go to DONE.
  - Otherwise go to CALC with counter = XLEN/BPC.
- CALC:
  - Each cycle retires BPC bits and decrements the counter.
  - Multiply uses shift-add on magnitudes with final sign correction and keeps the full 2*XLEN product.
  - Divide uses restoring division on magnitudes, producing quotient and remainder together.
  - When the counter reaches 0, go to DONE.
- DONE:
  - s_finished_o=1 and s_result_o holds the selected result.
  - If s_stall_i=1, stay in DONE; output stays stable.
  - If s_stall_i=0, go to IDLE next cycle; the cache is written at this point.
- Latency, with cycle 0 being the first cycle s_compute_i=1 in IDLE:
  - Iterating operations assert s_finished_o in cycle XLEN/BPC+1.
  - Special cases and cache hits assert it in cycle 1.
- Flush, in any state:
  - Next state is IDLE and s_finished_o=0 in the next cycle.
  - The partial computation is discarded; the cache keeps its prior contents.
  - Flush has priority over stall and over a new compute.
- s_compute_i dropping to 0 in CALC or DONE aborts to IDLE with the same effect as a flush.
- Back-to-back operations: a compute seen in IDLE in the cycle after DONE exits is a new instruction, and the cache is consulted.
- Result selection:
  - MUL returns product[XLEN-1:0].
  - MULH, MULHSU and MULHU return product[2XLEN-1:XLEN], with operand signedness per funct3.
  - DIV and DIVU return the quotient.
  - REM and REMU return the remainder.
  - Remainder sign follows the dividend.
- Special cases (no iteration):
  - Divisor 0: quotient = all ones; remainder = dividend.
  - Signed overflow (dividend = -2^(XLEN-1), divisor = -1): quotient = dividend; remainder = 0.
- Cache (CACHE_EN=1):
  - Stores op1, op2, the class (mul/div), the signedness pair, the full product or the quotient/remainder pair, and a valid bit.
  - A hit requires an identical class and identical operands.
  - For div classes, signedness must match: DIV/REM are signed, DIVU/REMU unsigned.
  - For mul classes, MUL matches any mul entry; MULH* requires an identical signedness pair.
  - Special-case results are also cached.
  - Invalidation happens on reset only.

Test Plan:
- XLEN=32, BPC=2. MUL 7 x 0xFFFFFFFD -> s_finished_o=1 first in cycle 17, result 0xFFFFFFEB; s_finished_o=0 in cycles 0-16.
- Immediately follow with MULH on the same operands -> cache hit, finished in cycle 1, result 0xFFFFFFFF. Repeat with CACHE_EN=0 -> finished in cycle 17, same result.
- DIV 0x80000000 / 0xFFFFFFFF -> cycle 1, result 0x80000000. Then REM on the same operands -> cycle 1, result 0.
- DIVU 13 / 0 -> cycle 1, result 0xFFFFFFFF. REMU 13 / 0 -> result 13. DIV -7 / 2 -> -3 (0xFFFFFFFD) in cycle 17. REM -7 / 2 -> -1.
- Assert s_flush_i in cycle 5 of a DIVU 100/7 -> s_finished_o never asserts and the FSM is in IDLE. A new DIVU 100/7 then iterates fully (no cache hit) -> result 14 in cycle 17.
- Hold s_stall_i=1 for 3 cycles at DONE of MULHU 0xFFFFFFFF x 0xFFFFFFFF -> s_finished_o=1 and result 0xFFFFFFFE stable for 4 cycles. Assert s_resetn_i low mid-CALC -> outputs are 0 immediately.
